rc4_ksa_engine: RTL

RC4 key-scheduling engine that answers the loop sequencer's start/done handshake on the DE1-SoC decryption datapath. When asked, it runs loop 1 (s[i] = i) and then loop 2 (the keyed swap pass) over the 256-byte S-box in on-chip RAM. It sits between the loop sequencer and the single-port S memory. It owns the S memory's address, write-data and write-enable lines for the duration of each loop.

---
 rtl/rc4_ksa_engine_if.sv | 44 ++++
 rtl/rc4_ksa_engine.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine_if.sv
// Handshake and S-memory bus between the loop sequencer / S RAM and the
// RC4 key-scheduling engine.
interface rc4_ksa_engine_if #(
    parameter int KEY_BYTES = 3
);
    logic                   first_loop_start;
    logic                   second_loop_start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic                   first_loop_done;
    logic                   second_loop_done;
    logic                   busy;
    logic [7:0]             s_address;
    logic [7:0]             s_data;
    logic                   s_wren;
    logic [7:0]             s_q;

    // Sequencer plus S RAM side
    modport master (
        output first_loop_start,
        output second_loop_start,
        output secret_key,
        output s_q,
        input  first_loop_done,
        input  second_loop_done,
        input  busy,
        input  s_address,
        input  s_data,
        input  s_wren
    );

    // Engine side
    modport slave (
        input  first_loop_start,
        input  second_loop_start,
        input  secret_key,
        input  s_q,
        output first_loop_done,
        output second_loop_done,
        output busy,
        output s_address,
        output s_data,
        output s_wren
    );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: loop 1 fills S with the identity permutation,
// loop 2 performs the keyed swap pass over a single-port S RAM with a
// one-cycle read latency.
module rc4_ksa_engine #(
    parameter int KEY_BYTES = 3
) (
    input  logic               clok,
    input  logic               rst,
    rc4_ksa_engine_if.slave    bus
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT_WR,
        RD_I,
        WAIT_I,
        RD_J,
        WAIT_J,
        WR_I,
        WR_J
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [KW-1:0]  keyIdx_q, keyIdx_d;
    logic           initOk_q, initOk_d;
    logic           firstDone_q, firstDone_d;
    logic           secondDone_q, secondDone_d;
    logic           firstDoneSet;
    logic           secondDoneSet;
    logic [7:0]     keyByte;
    logic [7:0]     sAddr;
    logic [7:0]     sData;
    logic           sWren;

    // Select key byte (i mod KEY_BYTES); byte 0 sits in the key's MSBs
    always_comb begin
        keyByte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (keyIdx_q == KW'(k)) begin
                keyByte = bus.secret_key[8*(KEY_BYTES-k)-1 -: 8];
            end
        end
    end

    // Next-state, datapath updates and memory-port drive for both loops
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        si_d          = si_q;
        sj_d          = sj_q;
        keyIdx_d      = keyIdx_q;
        initOk_d      = initOk_q;
        firstDoneSet  = 1'b0;
        secondDoneSet = 1'b0;
        sAddr         = i_q;
        sData         = 8'h00;
        sWren         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.first_loop_start && !firstDone_q) begin
                    i_d      = 8'h00;
                    initOk_d = 1'b0;
                    state_d  = INIT_WR;
                end else if (bus.second_loop_start && !secondDone_q && initOk_q) begin
                    i_d      = 8'h00;
                    j_d      = 8'h00;
                    keyIdx_d = '0;
                    state_d  = RD_I;
                end
            end
            INIT_WR: begin
                sAddr = i_q;
                sData = i_q;
                sWren = 1'b1;
                i_d   = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    firstDoneSet = 1'b1;
                    initOk_d     = 1'b1;
                    state_d      = IDLE;
                end
            end
            RD_I: begin
                sAddr   = i_q;
                state_d = WAIT_I;
            end
            WAIT_I: begin
                si_d    = bus.s_q;
                j_d     = j_q + bus.s_q + keyByte;
                state_d = RD_J;
            end
            RD_J: begin
                sAddr   = j_q;
                state_d = WAIT_J;
            end
            WAIT_J: begin
                sj_d    = bus.s_q;
                state_d = WR_I;
            end
            WR_I: begin
                sAddr   = i_q;
                sData   = sj_q;
                sWren   = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                sAddr    = j_q;
                sData    = si_q;
                sWren    = 1'b1;
                i_d      = i_q + 8'd1;
                keyIdx_d = (keyIdx_q == KW'(KEY_BYTES - 1)) ? '0 : keyIdx_q + KW'(1);
                if (i_q == 8'hFF) begin
                    secondDoneSet = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = RD_I;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Done flags rise at loop end and drop on the first clock seeing their start low
    always_comb begin
        firstDone_d  = firstDoneSet  ? 1'b1 : (bus.first_loop_start  ? firstDone_q  : 1'b0);
        secondDone_d = secondDoneSet ? 1'b1 : (bus.second_loop_start ? secondDone_q : 1'b0);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clok) begin
        if (rst) begin
            state_q      <= IDLE;
            i_q          <= 8'h00;
            j_q          <= 8'h00;
            si_q         <= 8'h00;
            sj_q         <= 8'h00;
            keyIdx_q     <= '0;
            initOk_q     <= 1'b0;
            firstDone_q  <= 1'b0;
            secondDone_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            keyIdx_q     <= keyIdx_d;
            initOk_q     <= initOk_d;
            firstDone_q  <= firstDone_d;
            secondDone_q <= secondDone_d;
        end
    end

    assign bus.first_loop_done  = firstDone_q;
    assign bus.second_loop_done = secondDone_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.s_address        = sAddr;
    assign bus.s_data           = sData;
    assign bus.s_wren           = sWren;
endmodule
